// File: rtl/multicycle_control_if.sv
`default_nettype none
// =============================================================================
// Module   : multicycle_control_if
// Purpose  : IR fields, memory handshake and datapath controls of the multi-cycle control FSM.
// Revision : 1.0 - initial release
// =============================================================================
interface multicycle_control_if #(
    parameter int ALUOP_WIDTH = 4
);
    logic [5:0]             OP;
    logic [5:0]             ALUFunction;
    logic                   Zero;
    logic                   MemReady;
    logic                   PCWrite;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic [1:0]             RegDst;
    logic [1:0]             MemtoReg;
    logic                   RegWrite;
    logic                   ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic [1:0]             PCSource;
    logic                   Illegal;
    logic                   BusError;
    logic [2:0]             State;

    modport master (
        input  OP, ALUFunction, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, BusError, State
    );

    modport slave (
        output OP, ALUFunction, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, BusError, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// =============================================================================
// Module   : multicycle_control
// Purpose  : Control FSM for a multi-cycle MIPS datapath with memory stall,
//            bus-error timeout and sticky illegal-opcode trap.
// Revision : 1.0 - initial release
// =============================================================================
module multicycle_control #(
    parameter int ALUOP_WIDTH = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int JR_ENABLE   = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    multicycle_control_if.master bus
);
    localparam int c_CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    localparam logic [ALUOP_WIDTH-1:0] c_ALU_R   = ALUOP_WIDTH'(4'b0111);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_ADD = ALUOP_WIDTH'(4'b0100);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_OR  = ALUOP_WIDTH'(4'b0101);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_AND = ALUOP_WIDTH'(4'b0110);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_SUB = ALUOP_WIDTH'(4'b0001);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_LW  = ALUOP_WIDTH'(4'b0010);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_SW  = ALUOP_WIDTH'(4'b0011);
    localparam logic [ALUOP_WIDTH-1:0] c_ALU_LUI = ALUOP_WIDTH'(4'b1000);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_waitCount;
    logic [5:0]           r_op;
    logic [5:0]           r_funct;
    logic                 r_illegal;
    logic                 r_busError;

    logic w_timeout;
    logic w_liveJr;
    logic w_liveExec;
    logic w_latchedJr;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_waitCount == c_CNT_W'(MEM_TIMEOUT));
        end else begin : g_noTimeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_liveJr    = (JR_ENABLE != 0) && (bus.OP == c_OP_RTYPE) && (bus.ALUFunction == c_FN_JR);
    assign w_liveExec  = bus.OP inside {c_OP_RTYPE, c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI,
                                        c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_BNE};
    assign w_latchedJr = (JR_ENABLE != 0) && (r_op == c_OP_RTYPE) && (r_funct == c_FN_JR);

    // The wait counter only survives while the FSM stays in a stalled memory state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_waitCount <= '0;
            r_op        <= '0;
            r_funct     <= '0;
            r_illegal   <= 1'b0;
            r_busError  <= 1'b0;
        end else begin
            r_waitCount <= '0;
            case (r_state)
                S_FETCH: begin
                    if (bus.MemReady) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state    <= S_TRAP;
                        r_busError <= 1'b1;
                    end else begin
                        r_waitCount <= r_waitCount + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_op    <= bus.OP;
                    r_funct <= bus.ALUFunction;
                    if (bus.OP == c_OP_J || bus.OP == c_OP_JAL || w_liveJr) begin
                        r_state <= S_FETCH;
                    end else if (w_liveExec) begin
                        r_state <= S_EXECUTE;
                    end else begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    if (r_op == c_OP_LW || r_op == c_OP_SW)
                        r_state <= S_MEMORY;
                    else if (r_op == c_OP_BEQ || r_op == c_OP_BNE || w_latchedJr)
                        r_state <= S_FETCH;
                    else
                        r_state <= S_WRITEBACK;
                end
                S_MEMORY: begin
                    if (bus.MemReady) begin
                        r_state <= (r_op == c_OP_LW) ? S_WRITEBACK : S_FETCH;
                    end else if (w_timeout) begin
                        r_state    <= S_TRAP;
                        r_busError <= 1'b1;
                    end else begin
                        r_waitCount <= r_waitCount + 1'b1;
                    end
                end
                S_WRITEBACK: r_state <= S_FETCH;
                S_TRAP:      r_state <= S_TRAP;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    logic                   w_pcWrite, w_iorD, w_memRead, w_memWrite, w_irWrite;
    logic [1:0]             w_regDst, w_memtoReg, w_aluSrcB, w_pcSource;
    logic                   w_regWrite, w_aluSrcA;
    logic [ALUOP_WIDTH-1:0] w_aluOp;

    always_comb begin
        w_pcWrite  = 1'b0;
        w_iorD     = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_irWrite  = 1'b0;
        w_regDst   = 2'b00;
        w_memtoReg = 2'b00;
        w_regWrite = 1'b0;
        w_aluSrcA  = 1'b0;
        w_aluSrcB  = 2'b00;
        w_aluOp    = '0;
        w_pcSource = 2'b00;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    w_memRead = 1'b1;
                    w_aluSrcB = 2'b01;
                    w_aluOp   = c_ALU_ADD;
                    w_irWrite = bus.MemReady;
                    w_pcWrite = bus.MemReady;
                end
                S_DECODE: begin
                    w_aluSrcB = 2'b11;
                    w_aluOp   = c_ALU_ADD;
                    if (bus.OP == c_OP_J || bus.OP == c_OP_JAL) begin
                        w_pcWrite  = 1'b1;
                        w_pcSource = 2'b10;
                    end
                    if (bus.OP == c_OP_JAL) begin
                        w_regWrite = 1'b1;
                        w_regDst   = 2'b10;
                        w_memtoReg = 2'b10;
                    end
                    if (w_liveJr) begin
                        w_pcWrite  = 1'b1;
                        w_pcSource = 2'b11;
                    end
                end
                S_EXECUTE: begin
                    w_aluSrcA = 1'b1;
                    w_aluSrcB = 2'b10;
                    case (r_op)
                        c_OP_ADDI: w_aluOp = c_ALU_ADD;
                        c_OP_ORI:  w_aluOp = c_ALU_OR;
                        c_OP_ANDI: w_aluOp = c_ALU_AND;
                        c_OP_LUI:  w_aluOp = c_ALU_LUI;
                        c_OP_LW:   w_aluOp = c_ALU_LW;
                        c_OP_SW:   w_aluOp = c_ALU_SW;
                        c_OP_BEQ, c_OP_BNE: begin
                            w_aluSrcB  = 2'b00;
                            w_aluOp    = c_ALU_SUB;
                            w_pcSource = 2'b01;
                            w_pcWrite  = (r_op == c_OP_BEQ) ? bus.Zero : ~bus.Zero;
                        end
                        default: begin
                            w_aluSrcB = 2'b00;
                            w_aluOp   = w_latchedJr ? '0 : c_ALU_R;
                        end
                    endcase
                end
                S_MEMORY: begin
                    w_iorD     = 1'b1;
                    w_memRead  = (r_op == c_OP_LW);
                    w_memWrite = (r_op == c_OP_SW);
                end
                S_WRITEBACK: begin
                    w_regWrite = 1'b1;
                    if (r_op == c_OP_RTYPE) w_regDst   = 2'b01;
                    if (r_op == c_OP_LW)    w_memtoReg = 2'b01;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWrite  = w_pcWrite;
    assign bus.IorD     = w_iorD;
    assign bus.MemRead  = w_memRead;
    assign bus.MemWrite = w_memWrite;
    assign bus.IRWrite  = w_irWrite;
    assign bus.RegDst   = w_regDst;
    assign bus.MemtoReg = w_memtoReg;
    assign bus.RegWrite = w_regWrite;
    assign bus.ALUSrcA  = w_aluSrcA;
    assign bus.ALUSrcB  = w_aluSrcB;
    assign bus.ALUOp    = w_aluOp;
    assign bus.PCSource = w_pcSource;
    assign bus.Illegal  = r_illegal;
    assign bus.BusError = r_busError;
    assign bus.State    = r_state;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Testbench for multicycle_control: cycle-by-cycle vector table plus
// hand-written trap, timeout and mid-instruction reset sequences.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_WIDTH(4)) bus ();
    multicycle_control #(.ALUOP_WIDTH(4), .MEM_TIMEOUT(15), .JR_ENABLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, iord, mr, mw, irw;
        logic [1:0] rdst, m2r;
        logic       rw, asa;
        logic [1:0] asb;
        logic [3:0] aop;
        logic [1:0] pcs;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    localparam logic [5:0] G = 6'h3f;  // garbage OP driven once the IR fields are latched

    vec_t  tbl[$];
    int    nTests = 0;
    int    nFail  = 0;
    outs_t act;

    assign act = {bus.State, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                  bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSource};

    function automatic outs_t o(input logic [2:0] st, input logic pcw, input logic iord,
                                input logic mr, input logic mw, input logic irw,
                                input logic [1:0] rdst, input logic [1:0] m2r, input logic rw,
                                input logic asa, input logic [1:0] asb, input logic [3:0] aop,
                                input logic [1:0] pcs);
        return {st, pcw, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, pcs};
    endfunction

    function automatic outs_t oFetch(input logic rdy);
        return o(3'd0, rdy, 1'b0, 1'b1, 1'b0, rdy, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 4'b0100, 2'd0);
    endfunction
    function automatic outs_t oDec();
        return o(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 4'b0100, 2'd0);
    endfunction
    function automatic outs_t oDj(input logic rw, input logic [1:0] rdst, input logic [1:0] m2r,
                                  input logic [1:0] pcs);
        return o(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdst, m2r, rw, 1'b0, 2'd3, 4'b0100, pcs);
    endfunction
    function automatic outs_t oExe(input logic pcw, input logic [1:0] asb, input logic [3:0] aop,
                                   input logic [1:0] pcs);
        return o(3'd2, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, asb, aop, pcs);
    endfunction
    function automatic outs_t oMem(input logic mr, input logic mw);
        return o(3'd3, 1'b0, 1'b1, mr, mw, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0);
    endfunction
    function automatic outs_t oWb(input logic [1:0] rdst, input logic [1:0] m2r);
        return o(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdst, m2r, 1'b1, 1'b0, 2'd0, 4'd0, 2'd0);
    endfunction
    function automatic outs_t oIdle(input logic [2:0] st);
        return o(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, input logic rdy, input outs_t e);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.zero = zero; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endtask

    // Called just after a rising edge: drive one cycle, check mid-cycle, advance.
    task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic zero, input logic rdy, input outs_t e);
        bus.OP = op; bus.ALUFunction = fn; bus.Zero = zero; bus.MemReady = rdy;
        @(negedge clk);
        check(name, 32'(act), 32'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.OP = '0; bus.ALUFunction = '0; bus.Zero = 1'b0; bus.MemReady = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("reset_outs", 32'(act), 32'(oIdle(3'd0)));
            check("reset_flags", 32'({bus.Illegal, bus.BusError}), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        add("r_fetch", 6'h00, 6'h20, 0, 1, oFetch(1));
        add("r_dec",   6'h00, 6'h20, 0, 1, oDec());
        add("r_exe",   G,     6'h00, 0, 1, oExe(0, 2'd0, 4'b0111, 2'd0));
        add("r_wb",    G,     6'h00, 0, 1, oWb(2'd1, 2'd0));
        add("addi_f",  6'h08, 6'h00, 0, 1, oFetch(1));
        add("addi_d",  6'h08, 6'h00, 0, 1, oDec());
        add("addi_e",  G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b0100, 2'd0));
        add("addi_wb", G,     6'h00, 0, 1, oWb(2'd0, 2'd0));
        add("ori_f",   6'h0d, 6'h00, 0, 1, oFetch(1));
        add("ori_d",   6'h0d, 6'h00, 0, 1, oDec());
        add("ori_e",   G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b0101, 2'd0));
        add("ori_wb",  G,     6'h00, 0, 1, oWb(2'd0, 2'd0));
        add("andi_f",  6'h0c, 6'h00, 0, 1, oFetch(1));
        add("andi_d",  6'h0c, 6'h00, 0, 1, oDec());
        add("andi_e",  G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b0110, 2'd0));
        add("andi_wb", G,     6'h00, 0, 1, oWb(2'd0, 2'd0));
        add("lui_f",   6'h0f, 6'h00, 0, 1, oFetch(1));
        add("lui_d",   6'h0f, 6'h00, 0, 1, oDec());
        add("lui_e",   G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b1000, 2'd0));
        add("lui_wb",  G,     6'h00, 0, 1, oWb(2'd0, 2'd0));
        add("lw_f",    6'h23, 6'h00, 0, 1, oFetch(1));
        add("lw_d",    6'h23, 6'h00, 0, 1, oDec());
        add("lw_e",    G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b0010, 2'd0));
        add("lw_m0",   G,     6'h00, 0, 0, oMem(1, 0));
        add("lw_m1",   G,     6'h00, 0, 0, oMem(1, 0));
        add("lw_m2",   G,     6'h00, 0, 0, oMem(1, 0));
        add("lw_m3",   G,     6'h00, 0, 1, oMem(1, 0));
        add("lw_wb",   G,     6'h00, 0, 1, oWb(2'd0, 2'd1));
        add("sw_f",    6'h2b, 6'h00, 0, 1, oFetch(1));
        add("sw_d",    6'h2b, 6'h00, 0, 1, oDec());
        add("sw_e",    G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b0011, 2'd0));
        add("sw_m",    G,     6'h00, 0, 1, oMem(0, 1));
        add("beq1_f",  6'h04, 6'h00, 0, 1, oFetch(1));
        add("beq1_d",  6'h04, 6'h00, 0, 1, oDec());
        add("beq1_e",  G,     6'h00, 1, 1, oExe(1, 2'd0, 4'b0001, 2'd1));
        add("bne1_f",  6'h05, 6'h00, 0, 1, oFetch(1));
        add("bne1_d",  6'h05, 6'h00, 0, 1, oDec());
        add("bne1_e",  G,     6'h00, 1, 1, oExe(0, 2'd0, 4'b0001, 2'd1));
        add("beq0_f",  6'h04, 6'h00, 0, 1, oFetch(1));
        add("beq0_d",  6'h04, 6'h00, 0, 1, oDec());
        add("beq0_e",  G,     6'h00, 0, 1, oExe(0, 2'd0, 4'b0001, 2'd1));
        add("bne0_f",  6'h05, 6'h00, 0, 1, oFetch(1));
        add("bne0_d",  6'h05, 6'h00, 0, 1, oDec());
        add("bne0_e",  G,     6'h00, 0, 1, oExe(1, 2'd0, 4'b0001, 2'd1));
        add("stall_f0", 6'h02, 6'h00, 0, 0, oFetch(0));
        add("stall_f1", 6'h02, 6'h00, 0, 0, oFetch(0));
        add("j_f",     6'h02, 6'h00, 0, 1, oFetch(1));
        add("j_d",     6'h02, 6'h00, 0, 1, oDj(0, 2'd0, 2'd0, 2'd2));
        add("jal_f",   6'h03, 6'h00, 0, 1, oFetch(1));
        add("jal_d",   6'h03, 6'h00, 0, 1, oDj(1, 2'd2, 2'd2, 2'd2));
        add("jr_f",    6'h00, 6'h08, 0, 1, oFetch(1));
        add("jr_d",    6'h00, 6'h08, 0, 1, oDj(0, 2'd0, 2'd0, 2'd3));
        add("after_jr", 6'h00, 6'h00, 0, 0, oFetch(0));

        foreach (tbl[i]) step(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].zero, tbl[i].rdy, tbl[i].exp);
        check("flags_clean", 32'({bus.Illegal, bus.BusError}), 32'd0);

        // Illegal opcode: trap is sticky regardless of memory activity.
        step("ill_f", G, 6'h00, 0, 1, oFetch(1));
        step("ill_d", G, 6'h00, 0, 1, oDec());
        for (int c = 0; c < 20; c++) begin
            bus.MemReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trap_outs", 32'(act), 32'(oIdle(3'd7)));
            check("trap_illegal", 32'({bus.Illegal, bus.BusError}), 32'b10);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        check("async_reset_outs", 32'(act), 32'(oIdle(3'd0)));
        check("async_reset_flags", 32'({bus.Illegal, bus.BusError}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset while SW is stalled in MEMORY must kill the write at once.
        step("swr_f", 6'h2b, 6'h00, 0, 1, oFetch(1));
        step("swr_d", 6'h2b, 6'h00, 0, 1, oDec());
        step("swr_e", G,     6'h00, 0, 1, oExe(0, 2'd2, 4'b0011, 2'd0));
        bus.MemReady = 1'b0;
        @(negedge clk);
        check("swr_m_stall", 32'(act), 32'(oMem(0, 1)));
        #1 reset = 1'b0;
        #1 check("swr_reset_nowrite", 32'(act), 32'(oIdle(3'd0)));
        @(posedge clk);
        #1 reset = 1'b1;
        step("swr_refetch", 6'h02, 6'h00, 0, 1, oFetch(1));
        step("swr_j", 6'h02, 6'h00, 0, 1, oDj(0, 2'd0, 2'd0, 2'd2));

        // MemReady arriving on the timeout cycle wins over the bus error.
        for (int c = 0; c < 15; c++) step("to_wait", 6'h00, 6'h20, 0, 0, oFetch(0));
        step("to_ready_wins", 6'h00, 6'h20, 0, 1, oFetch(1));
        step("to_dec", 6'h00, 6'h20, 0, 1, oDec());
        check("to_no_buserr", 32'(bus.BusError), 32'd0);
        step("to_exe", G, 6'h00, 0, 1, oExe(0, 2'd0, 4'b0111, 2'd0));
        step("to_wb",  G, 6'h00, 0, 1, oWb(2'd1, 2'd0));

        // Sixteen stalled FETCH cycles exhaust MEM_TIMEOUT=15.
        for (int c = 0; c < 16; c++) step("be_wait", 6'h00, 6'h20, 0, 0, oFetch(0));
        @(negedge clk);
        check("be_trap_outs", 32'(act), 32'(oIdle(3'd7)));
        check("be_flags", 32'({bus.Illegal, bus.BusError}), 32'b01);
        repeat (3) @(posedge clk);
        bus.MemReady = 1'b1;
        @(negedge clk);
        check("be_sticky", 32'({bus.State, bus.BusError}), 32'({3'd7, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
`default_nettype wire
